// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg
// Shared constants for the Basys3 seven-segment scan driver.
//   - Active-low segment patterns, ordered {g,f,e,d,c,b,a}
//   - ANODES_OFF : all four common anodes released (active low)
//   - NUM_DIGITS : number of multiplexed digits on the board
// ============================================================================
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'b1111;

endpackage

// File: rtl/bcd_to_seg7.sv
// ============================================================================
// bcd_to_seg7
// Combinational BCD to active-low seven-segment decoder.
// Ports:
//   bcd : 4-bit BCD digit; codes 10..15 are not valid BCD
//   seg : active-low segments {g,f,e,d,c,b,a}
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Invalid BCD codes show a dash so a converter fault is visible on the display
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver
// Time-multiplexed driver for the Basys3 4-digit common-anode display.
// Digits are captured into shadow registers on a load strobe and scanned one
// per refresh slot, with a dark gap at the start of each slot to stop ghosting.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   load               : single-cycle capture strobe for all inputs below
//   bcd0..bcd3         : BCD digits, bcd0 = LSB, bcd3 = MSB
//   dp_en, dp_pos      : decimal point enable and digit index
//   blank_en           : leading-zero blanking enable
//   an                 : active-low anodes, an[k] drives digit k
//   seg                : active-low segments {g,f,e,d,c,b,a}
//   dp                 : active-low decimal point
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GAP         = 16
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [3:0]            bcd0,
    input  logic [3:0]            bcd1,
    input  logic [3:0]            bcd2,
    input  logic [3:0]            bcd3,
    input  logic                  dp_en,
    input  logic [1:0]            dp_pos,
    input  logic                  blank_en,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP);

    logic [CNT_W-1:0]            cnt;
    logic [1:0]                  idx;
    logic [NUM_DIGITS-1:0][3:0]  digit;
    logic                        dp_en_q;
    logic [1:0]                  dp_pos_q;
    logic                        blank_en_q;
    logic [NUM_DIGITS-1:0]       lead_zero;
    logic [3:0]                  cur_digit;
    logic [6:0]                  cur_seg;
    logic                        blanked;

    // Slot prescaler: idx advances once per REFRESH_DIV cycles, wrapping 3 -> 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow registers decouple the display from the converter's update timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit      <= '0;
            dp_en_q    <= 1'b0;
            dp_pos_q   <= 2'd0;
            blank_en_q <= 1'b0;
        end else if (load) begin
            digit      <= {bcd3, bcd2, bcd1, bcd0};
            dp_en_q    <= dp_en;
            dp_pos_q   <= dp_pos;
            blank_en_q <= blank_en;
        end
    end

    // lead_zero[k] is set when digit k and every more significant digit are 0;
    // the units digit is never a leading zero so a value of 0 still shows "0"
    always_comb begin
        lead_zero    = '0;
        lead_zero[3] = (digit[3] == 4'd0);
        lead_zero[2] = lead_zero[3] && (digit[2] == 4'd0);
        lead_zero[1] = lead_zero[2] && (digit[1] == 4'd0);
        lead_zero[0] = 1'b0;
    end

    assign cur_digit = digit[idx];
    assign blanked   = blank_en_q && lead_zero[idx];

    bcd_to_seg7 u_decode (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    // Registered outputs; everything is dark during the first GAP cycles of a
    // slot so the previous digit's segments never flash on the next anode.
    // A blanked digit keeps its anode so a selected decimal point still shows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= ANODES_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (cnt < GAP_END) begin
            an  <= ANODES_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= blanked ? SEG_BLANK : cur_seg;
            dp  <= !(dp_en_q && (dp_pos_q == idx));
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with REFRESH_DIV=8, GAP=2.
// Expected outputs come from a cycle-count model: the number of clock edges
// since reset gives the slot position directly, and the digits in force are
// those captured by loads before the edge that produced the outputs.
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DIV = 8;
    localparam int GP  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] bcd0, bcd1, bcd2, bcd3;
    logic       dp_en;
    logic [1:0] dp_pos;
    logic       blank_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int compared   = 0;
    int mismatched = 0;

    logic [6:0] seg_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    seg7_scan_driver #(.REFRESH_DIV(DIV), .GAP(GP)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .bcd0     (bcd0),
        .bcd1     (bcd1),
        .bcd2     (bcd2),
        .bcd3     (bcd3),
        .dp_en    (dp_en),
        .dp_pos   (dp_pos),
        .blank_en (blank_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    // Model state: cycles = edges since reset; m_* = latest captured values;
    // s_* = values that were in force before the most recent edge
    int              cycles;
    logic [3:0][3:0] m_dig, s_dig;
    logic            m_dp_en, s_dp_en, m_blank, s_blank;
    logic [1:0]      m_dp_pos, s_dp_pos;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles   <= 0;
            m_dig    <= '0;  s_dig    <= '0;
            m_dp_en  <= 1'b0; s_dp_en  <= 1'b0;
            m_dp_pos <= 2'd0; s_dp_pos <= 2'd0;
            m_blank  <= 1'b0; s_blank  <= 1'b0;
        end else begin
            cycles   <= cycles + 1;
            s_dig    <= m_dig;
            s_dp_en  <= m_dp_en;
            s_dp_pos <= m_dp_pos;
            s_blank  <= m_blank;
            if (load) begin
                m_dig    <= {bcd3, bcd2, bcd1, bcd0};
                m_dp_en  <= dp_en;
                m_dp_pos <= dp_pos;
                m_blank  <= blank_en;
            end
        end
    end

    // Expected {an, seg, dp} from slot arithmetic and the display rules
    function automatic logic [11:0] expected_out();
        int         m, pos, slot;
        logic [3:0] a;
        logic [6:0] s;
        logic       d, all_zero;
        if (cycles == 0) return 12'hFFF;
        m    = cycles - 1;
        pos  = m % DIV;
        slot = (m / DIV) % 4;
        if (pos < GP) return 12'hFFF;
        a       = 4'b1111;
        a[slot] = 1'b0;
        all_zero = 1'b1;
        for (int k = 3; k >= slot; k--)
            if (s_dig[k] != 4'd0) all_zero = 1'b0;
        if (s_blank && slot != 0 && all_zero) s = 7'b1111111;
        else                                  s = seg_table[s_dig[slot]];
        d = !(s_dp_en && (s_dp_pos == 2'(slot)));
        return {a, s, d};
    endfunction

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 2) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic drive_load(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0,
                              input logic de, input logic [1:0] dpp, input logic be);
        load = 1'b1;
        bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
        dp_en = de; dp_pos = dpp; blank_en = be;
    endtask

    // Reset asserted before any clock edge must darken the display at once
    task automatic test_reset();
        rst = 1'b0; load = 1'b0;
        bcd0 = 4'd0; bcd1 = 4'd0; bcd2 = 4'd0; bcd3 = 4'd0;
        dp_en = 1'b0; dp_pos = 2'd0; blank_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        compared++;
        if ({an, seg, dp} !== 12'hFFF) begin
            mismatched++;
            $display("[TB] FAIL reset_async actual an=%b seg=%b dp=%b required an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        repeat (3) @(negedge clk);
        compared++;
        if ({an, seg, dp} !== 12'hFFF) begin
            mismatched++;
            $display("[TB] FAIL reset_held actual an=%b seg=%b dp=%b required an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        rst = 1'b0;
    endtask

    // No load: all digits 0, full scan with gaps, then wrap back to digit 0
    task automatic test_default_scan();
        logic [11:0] e;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            e = expected_out();
            compared++;
            if ({an, seg, dp} !== e) begin
                mismatched++;
                $display("[TB] FAIL default_scan cyc=%0d actual an=%b seg=%b dp=%b required an=%b seg=%b dp=%b", i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (i == 2) begin
                compared++;
                if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
                    mismatched++;
                    $display("[TB] FAIL first_digit actual an=%b seg=%b dp=%b required an=1110 seg=1000000 dp=1", an, seg, dp);
                end
            end
        end
    endtask

    // Digits 1,2,3,4 with the decimal point on digit 2
    task automatic test_digits_dp();
        logic [11:0] e;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            e = expected_out();
            compared++;
            if ({an, seg, dp} !== e) begin
                mismatched++;
                $display("[TB] FAIL digits_dp cyc=%0d actual an=%b seg=%b dp=%b required an=%b seg=%b dp=%b", i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (i == 0) drive_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 2'd2, 1'b0);
            else        load = 1'b0;
        end
    endtask

    // Leading-zero blanking on 0,0,5,0 and on all zeros
    task automatic test_blanking();
        logic [11:0] e;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            e = expected_out();
            compared++;
            if ({an, seg, dp} !== e) begin
                mismatched++;
                $display("[TB] FAIL blanking cyc=%0d actual an=%b seg=%b dp=%b required an=%b seg=%b dp=%b", i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (i == 0)       drive_load(4'd0, 4'd0, 4'd5, 4'd0, 1'b1, 2'd3, 1'b1);
            else if (i == 40) drive_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b1);
            else              load = 1'b0;
        end
    endtask

    // Invalid BCD on digit 1 shows a dash
    task automatic test_dash();
        logic [11:0] e;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            e = expected_out();
            compared++;
            if ({an, seg, dp} !== e) begin
                mismatched++;
                $display("[TB] FAIL dash cyc=%0d actual an=%b seg=%b dp=%b required an=%b seg=%b dp=%b", i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (i == 0) drive_load(4'd7, 4'hF, 4'hC, 4'd9, 1'b0, 2'd1, 1'b1);
            else        load = 1'b0;
        end
    endtask

    // Random loads at random times, including runs with load held high
    task automatic test_random();
        logic [11:0] e;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            e = expected_out();
            compared++;
            if ({an, seg, dp} !== e) begin
                mismatched++;
                $display("[TB] FAIL random cyc=%0d actual an=%b seg=%b dp=%b required an=%b seg=%b dp=%b", i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if ($urandom_range(0, 3) == 0)
                drive_load(rand_digit(), rand_digit(), rand_digit(), rand_digit(),
                           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)));
            else
                load = 1'b0;
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    // Reset in slot 2 at cnt 5 clears outputs immediately and the shadow digits
    task automatic test_reset_midslot();
        logic [11:0] e;
        bit          found = 1'b0;
        drive_load(4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 2'd0, 1'b0);
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            e = expected_out();
            compared++;
            if ({an, seg, dp} !== e) begin
                mismatched++;
                $display("[TB] FAIL pre_reset cyc=%0d actual an=%b seg=%b dp=%b required an=%b seg=%b dp=%b", i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (cycles % 32 == 21) found = 1'b1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("[TB] FAIL midslot_wait actual not_reached required cnt5_idx2");
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({an, seg, dp} !== 12'hFFF) begin
            mismatched++;
            $display("[TB] FAIL midslot_async actual an=%b seg=%b dp=%b required an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            e = expected_out();
            compared++;
            if ({an, seg, dp} !== e) begin
                mismatched++;
                $display("[TB] FAIL post_reset cyc=%0d actual an=%b seg=%b dp=%b required an=%b seg=%b dp=%b", i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (i < 2) begin
                compared++;
                if ({an, seg, dp} !== 12'hFFF) begin
                    mismatched++;
                    $display("[TB] FAIL restart_gap cyc=%0d actual an=%b seg=%b dp=%b required an=1111 seg=1111111 dp=1", i, an, seg, dp);
                end
            end else if (i == 2) begin
                compared++;
                if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
                    mismatched++;
                    $display("[TB] FAIL restart_digit0 actual an=%b seg=%b dp=%b required an=1110 seg=1000000 dp=1", an, seg, dp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_scan();
        test_digits_dp();
        test_blanking();
        test_dash();
        test_random();
        test_reset_midslot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
